// File: rtl/shift_left_iterative.sv
// Multi-cycle logical left shifter: shifts one bit per clock and records whether
// any set bit fell off the MSB. Valid/ready handshake on both request and result.
module shift_left_iterative #(
  parameter int N = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [N-1:0]         i_in,
  input  logic [$clog2(N)-1:0] i_shamt,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [N-1:0]         o_out,
  output logic                 o_lost,
  output logic                 o_busy
);

  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_acc;
  logic [SW-1:0] r_count;
  logic          r_lost;

  // SHIFT is only entered with a nonzero count and left when it reaches one,
  // so the count never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_lost  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_acc   <= i_in;
            r_count <= i_shamt;
            r_lost  <= 1'b0;
            r_state <= (i_shamt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_acc   <= {r_acc[N-2:0], 1'b0};
          r_lost  <= r_lost | r_acc[N-1];
          r_count <= r_count - SW'(1);
          if (r_count == SW'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request side is held off while reset is asserted even though the state is IDLE.
  assign o_in_ready  = (r_state == IDLE) && i_rst_n;
  assign o_out_valid = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);
  assign o_out       = r_acc;
  assign o_lost      = r_lost;

endmodule

// File: tb/tb_shift_left_iterative.sv
// Directed and randomised checks for shift_left_iterative: latency, result,
// lost-bit flag, backpressure and reset abandonment.
module tb_shift_left_iterative;

  localparam int N = 32;

  logic          clk;
  logic          rstN;
  logic          inValid;
  logic          inReady;
  logic [N-1:0]  inData;
  logic [4:0]    shamt;
  logic          outValid;
  logic          outReady;
  logic [N-1:0]  outData;
  logic          lost;
  logic          busy;

  int nCompared;
  int nMismatched;

  shift_left_iterative #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_in        (inData),
    .i_shamt     (shamt),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out       (outData),
    .o_lost      (lost),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] d, input logic [4:0] s);
    inData  = d;
    shamt   = s;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!outValid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    tick();
    tick();
    nCompared++;
    if (inReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_in_ready_gated actual=%b required=0", inReady);
    end
    rstN = 1'b1;
    #1;
    nCompared++;
    if ({outValid, busy, lost, inReady} !== 4'b0001 || outData !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state actual v=%b b=%b l=%b r=%b out=%h required 0/0/0/1 out=0",
               outValid, busy, lost, inReady, outData);
    end
  endtask

  task automatic test_shift31();
    int n;
    outReady = 1'b1;
    applyStimulus(32'h0000_0001, 5'd31);
    waitValid(n);
    nCompared++;
    if (n !== 31) begin
      nMismatched++;
      $display("[TB] FAIL shift31_latency actual=%0d required=31", n);
    end
    nCompared++;
    if (outData !== 32'h8000_0000 || lost !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL shift31_result actual=%h/%b required=80000000/0", outData, lost);
    end
    tick();
    nCompared++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL shift31_handoff actual v=%b r=%b required v=0 r=1", outValid, inReady);
    end
  endtask

  task automatic test_shift4();
    int n;
    outReady = 1'b1;
    applyStimulus(32'hFFFF_FFFF, 5'd4);
    waitValid(n);
    nCompared++;
    if (n !== 4 || outData !== 32'hFFFF_FFF0 || lost !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL shift4_ones actual lat=%0d out=%h lost=%b required 4/fffffff0/1",
               n, outData, lost);
    end
    tick();
    applyStimulus(32'h0FFF_FFFF, 5'd4);
    waitValid(n);
    nCompared++;
    if (n !== 4 || outData !== 32'hFFFF_FFF0 || lost !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL shift4_nolost actual lat=%0d out=%h lost=%b required 4/fffffff0/0",
               n, outData, lost);
    end
    tick();
  endtask

  task automatic test_shift0();
    outReady = 1'b1;
    applyStimulus(32'hA5A5_A5A5, 5'd0);
    nCompared++;
    if (outValid !== 1'b1 || outData !== 32'hA5A5_A5A5 || lost !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL shift0 actual v=%b out=%h lost=%b required 1/a5a5a5a5/0",
               outValid, outData, lost);
    end
    tick();
    nCompared++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL shift0_handoff actual v=%b r=%b required v=0 r=1", outValid, inReady);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int seen;
    outReady = 1'b0;
    applyStimulus(32'h0000_0001, 5'd3);
    waitValid(n);
    nCompared++;
    if (n !== 3 || outData !== 32'h8) begin
      nMismatched++;
      $display("[TB] FAIL bp_first actual lat=%0d out=%h required 3/8", n, outData);
    end
    for (int i = 0; i < 5; i++) begin
      inValid = i[0];
      inData  = 32'hDEAD_0000 + i;
      shamt   = 5'd0;
      tick();
      nCompared++;
      if (outValid !== 1'b1 || outData !== 32'h8 || lost !== 1'b0 || inReady !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL bp_hold%0d actual v=%b out=%h l=%b r=%b required 1/8/0/0",
                 i, outValid, outData, lost, inReady);
      end
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    nCompared++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL bp_handoff actual v=%b r=%b required v=0 r=1", outValid, inReady);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (outValid) seen++;
    end
    nCompared++;
    if (seen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL bp_second_accept actual=%0d required=0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    outReady = 1'b1;
    applyStimulus(32'hFFFF_FFFF, 5'd20);
    for (int i = 0; i < 4; i++) tick();
    rstN = 1'b0;
    #1;
    nCompared++;
    if (inReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rstmid_gated actual=%b required=0", inReady);
    end
    tick();
    rstN = 1'b1;
    #1;
    nCompared++;
    if ({outValid, busy, lost, inReady} !== 4'b0001 || outData !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL rstmid_state actual v=%b b=%b l=%b r=%b out=%h required 0/0/0/1 out=0",
               outValid, busy, lost, inReady, outData);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (outValid) seen++;
    end
    nCompared++;
    if (seen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL rstmid_stale actual=%0d required=0", seen);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   d;
    logic [4:0]     s;
    logic [2*N-1:0] wide;
    logic [N-1:0]   expOut;
    logic           expLost;
    int n;
    int stall;
    for (int k = 0; k < 200; k++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      wide    = {32'h0, d} << s;
      expOut  = wide[N-1:0];
      expLost = |wide[2*N-1:N];
      outReady = 1'b0;
      applyStimulus(d, s);
      waitValid(n);
      nCompared++;
      if (n !== int'(s) || outData !== expOut || lost !== expLost) begin
        nMismatched++;
        $display("[TB] FAIL rand%0d in=%h s=%0d actual lat=%0d out=%h lost=%b required %0d/%h/%b",
                 k, d, s, n, outData, lost, s, expOut, expLost);
      end
      stall = $urandom_range(0, 3);
      for (int j = 0; j < stall; j++) begin
        tick();
        nCompared++;
        if (outValid !== 1'b1 || outData !== expOut || lost !== expLost) begin
          nMismatched++;
          $display("[TB] FAIL rand%0d_stall actual v=%b out=%h l=%b required 1/%h/%b",
                   k, outValid, outData, lost, expOut, expLost);
        end
      end
      outReady = 1'b1;
      tick();
      nCompared++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL rand%0d_handoff actual v=%b r=%b required 0/1", k, outValid, inReady);
      end
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rstN     = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    shamt    = '0;
    outReady = 1'b0;
    test_reset();
    test_shift31();
    test_shift4();
    test_shift0();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
